// File: rtl/prio_encoder_reg.sv
// rtl/prio_encoder_reg.sv - registered priority encoder with valid/ready output stage
// Define PRIO_ENC_RR_EN for round-robin priority; otherwise the lowest set index wins.
module prio_encoder_reg #(
  parameter  int WIDTH  = 8,
  localparam int CODE_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] code,
  output logic              none,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [CODE_W:0] WIDTH_C = (CODE_W+1)'(WIDTH);

  logic [CODE_W-1:0] code_q, code_d;
  logic              none_q, none_d;
  logic              valid_q, valid_d;
  logic              accept;
  logic [WIDTH-1:0]  rot;
  logic [CODE_W-1:0] base;
  logic              found;
  logic [CODE_W-1:0] enc_code;

`ifdef PRIO_ENC_RR_EN
  logic [CODE_W-1:0]  ptr_q, ptr_d;
  logic [2*WIDTH-1:0] dbl;
  logic [CODE_W:0]    sum;
  logic [CODE_W:0]    nxt;

  // Rotate so that bit 0 of rot is the request at ptr; the fixed search below then
  // finds the first request at or after ptr, and ptr is added back modulo WIDTH.
  always_comb begin
    dbl = {sel, sel} >> ptr_q;
    rot = dbl[WIDTH-1:0];
  end

  always_comb begin
    sum = {1'b0, base} + {1'b0, ptr_q};
    if (sum >= WIDTH_C) begin
      sum = sum - WIDTH_C;
    end
    enc_code = found ? sum[CODE_W-1:0] : '0;
  end

  always_comb begin
    nxt = {1'b0, enc_code} + (CODE_W+1)'(1);
    if (nxt == WIDTH_C) begin
      nxt = '0;
    end
    ptr_d = (accept && found) ? nxt[CODE_W-1:0] : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    rot      = sel;
    enc_code = base;
  end
`endif

  // Descending scan: the last hit assigned is the lowest set index.
  always_comb begin
    found = 1'b0;
    base  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        base  = CODE_W'(i);
      end
    end
  end

  always_comb begin
    in_ready = !valid_q || out_ready;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    code_d  = code_q;
    none_d  = none_q;
    valid_d = valid_q;
    if (accept) begin
      code_d  = enc_code;
      none_d  = !found;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q  <= '0;
      none_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      none_q  <= none_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    code      = code_q;
    none      = none_q;
    out_valid = valid_q;
  end

endmodule

// File: tb/tb_prio_encoder_reg.sv
// tb/tb_prio_encoder_reg.sv - directed bench for prio_encoder_reg (WIDTH=8)
// Round-robin expectations apply when PRIO_ENC_RR_EN is defined.
module tb_prio_encoder_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sel;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] code;
  logic       none;
  logic       out_valid;
  logic       out_ready;

  int errors = 0;
  int checks = 0;

  prio_encoder_reg #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .code      (code),
    .none      (none),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sel = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_none", 32'(none), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // one-hot sweep at full throughput
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 8'(1 << i);
      step();
      chk($sformatf("sweep_code_%0d", i), 32'(code), 32'(i));
      chk($sformatf("sweep_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("sweep_none_%0d", i), 32'(none), 32'd0);
    end
    sel = 8'hFF;
    step();
    chk("all_ones_code", 32'(code), 32'd0);

    sel = 8'h00;
    step();
    chk("zero_valid", 32'(out_valid), 32'd1);
    chk("zero_none", 32'(none), 32'd1);
    chk("zero_code", 32'(code), 32'd0);

    in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // backpressure
    in_valid = 1'b1; sel = 8'h40;
    step();
    chk("bp_code", 32'(code), 32'd6);
    out_ready = 1'b0; sel = 8'h01;
    #1;
    chk("bp_in_ready0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_hold_code_%0d", i), 32'(code), 32'd6);
      chk($sformatf("bp_hold_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_next_code", 32'(code), 32'd0);
    chk("bp_next_valid", 32'(out_valid), 32'd1);

    // reset mid-operation
    sel = 8'h20;
    step();
    chk("mid_code", 32'(code), 32'd5);
    out_ready = 1'b0; rst = 1'b1; sel = 8'h08;
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_code", 32'(code), 32'd0);
    chk("mid_rst_none", 32'(none), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("mid_rst_no_accept", 32'(out_valid), 32'd0);

    // priority order with all requests active
    in_valid = 1'b1; out_ready = 1'b1; sel = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
`ifdef PRIO_ENC_RR_EN
      chk($sformatf("rr_ff_%0d", i), 32'(code), 32'(i % 8));
`else
      chk($sformatf("fix_ff_%0d", i), 32'(code), 32'd0);
`endif
    end
    sel = 8'h81;
    step();
`ifdef PRIO_ENC_RR_EN
    chk("rr_81_a", 32'(code), 32'd7);
`else
    chk("fix_81_a", 32'(code), 32'd0);
`endif
    step();
    chk("prio_81_b", 32'(code), 32'd0);

    // stalled result must not be disturbed by new sel values
    out_ready = 1'b0; sel = 8'h10;
    step();
    chk("stall_code", 32'(code), 32'd0);
    chk("stall_none", 32'(none), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prio_encoder_reg.md
Name: prio_encoder_reg

Overview:
- Parametrised, registered priority encoder for request vectors of any width, with a valid/ready output handshake.
- Accepts a request vector, resolves the winning index and holds it in a one-entry output register until it is consumed.
- Sits between request sources (interrupt lines, arbitration requests) and a consumer that may stall.
- Optionally rotates priority round-robin for fairness.

Parameters:
- WIDTH, default 8: number of request lines; legal range 2..256.
- CODE_W, default $clog2(WIDTH): width of the encoded output; localparam, derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- sel  input  WIDTH  request vector; bit i set = request i active.
- in_valid  input  1  sel is valid this cycle.
- in_ready  output  1  block can accept sel this cycle.
- code  output  CODE_W  encoded index of the winning request.
- none  output  1  accepted vector had no bits set.
- out_valid  output  1  code/none hold an unconsumed result.
- out_ready  input  1  consumer takes the result this cycle.

Behaviour:
- Reset (rst=1 at posedge): code=0, none=0, out_valid=0, round-robin pointer=0. Reset overrides any simultaneous accept or consume.
- in_ready = !out_valid || out_ready. This is combinational and has no dependency on in_valid.
- Accept occurs when in_valid && in_ready. On the next posedge:
  - code/none load the encode result of the accepted sel.
  - out_valid=1.
  - Latency is exactly 1 cycle from accept to out_valid.
- Consume occurs when out_valid && out_ready. If a consume happens without an accept in the same cycle, out_valid=0 next cycle.
- Simultaneous consume and accept: the new result replaces the old one, out_valid stays 1, and no bubble is inserted (full throughput of 1 result per cycle).
- Stall (out_valid=1, out_ready=0): code/none/out_valid hold, in_ready=0, and sel/in_valid are ignored.
- Fixed-priority encode (default): the lowest set index wins. Example: sel=8'b0010_1000 gives code=3.
- Zero vector: if sel has no bits set, code=0 and none=1, and the result is still delivered with out_valid=1. If any bit is set, none=0.
- code is never X. Every accepted result drives all CODE_W bits.
- When WIDTH is not a power of two, code values >= WIDTH are never produced.
- sel is sampled only at accept. Changes on sel while in_ready=0 have no effect.

Optional Feature:
- Macro: PRIO_ENC_RR_EN.
- Defined: round-robin priority.
  - Search starts at pointer ptr (CODE_W bits) and wraps modulo WIDTH: indices ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1.
  - On an accept with a non-zero sel, ptr becomes (winner+1) mod WIDTH. When winner=WIDTH-1, ptr wraps to 0.
  - On an accept with a zero sel, ptr is unchanged.
  - ptr updates only on accept, never on stall or consume.
  - Reset sets ptr=0.
- Not defined: no ptr register exists; fixed lowest-index priority applies.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles and release -> code=0, none=0, out_valid=0, in_ready=1.
- Fixed-priority sweep, WIDTH=8, out_ready=1: present one-hot sel=1<<i for i=0..7 on consecutive cycles -> code=i exactly one cycle after each accept, out_valid held at 1 continuously (no bubbles). Then sel=8'hFF -> code=0.
- Zero vector: sel=8'h00 with in_valid=1 -> next cycle out_valid=1, none=1, code=0.
- Backpressure: accept sel=8'h40 and hold out_ready=0 for 3 cycles while sel changes to 8'h01 -> code stays 6, in_ready=0 throughout. Raise out_ready -> result consumed; a same-cycle accept of 8'h01 gives code=0 next cycle.
- Reset mid-operation: out_valid=1 with code=5 and out_ready=0; assert rst with in_valid=1 -> next cycle out_valid=0, code=0, no accept recorded.
- Round-robin (PRIO_ENC_RR_EN, WIDTH=8): sel=8'hFF accepted 9 times with out_ready=1 -> code sequence 0,1,2,3,4,5,6,7,0. Then sel=8'h81 following a winner of 0 -> code=7, and the next sel=8'h81 -> code=0.
